// File: rtl/fixed_shrink_pkg.sv
// Shared types and the fixed-point cast helper for the shrink activation.
// The cast aligns fractional bits, then saturates to a signed output range.
package fixed_shrink_pkg;

    typedef enum logic {
        SHRINK_HARD = 1'b0,
        SHRINK_SOFT = 1'b1
    } shrink_mode_e;

    localparam int CAST_W = 32;

    // Arithmetic shift to the output fraction, then clamp to out_w signed bits
    function automatic logic signed [CAST_W-1:0] fx_cast(
        input logic signed [CAST_W-1:0] x,
        input int                       in_frac,
        input int                       out_frac,
        input int                       out_w
    );
        logic signed [CAST_W-1:0] a;
        logic signed [CAST_W-1:0] hi;
        logic signed [CAST_W-1:0] lo;
        if (out_frac < in_frac) begin
            a = x >>> (in_frac - out_frac);
        end else begin
            a = x <<< (out_frac - in_frac);
        end
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (a > hi) begin
            fx_cast = hi;
        end else if (a < lo) begin
            fx_cast = lo;
        end else begin
            fx_cast = a;
        end
    endfunction

endpackage

// File: rtl/fixed_shrink_cast.sv
// Combinational format conversion of one element.
// Shift to the output fraction and saturate to the output width.
module fixed_shrink_cast #(
    parameter int IN_W     = 9,
    parameter int IN_FRAC  = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 4
) (
    input  logic signed [IN_W-1:0]  x,
    output logic        [OUT_W-1:0] y
);
    import fixed_shrink_pkg::*;

    logic signed [CAST_W-1:0] wide;
    logic signed [CAST_W-1:0] res;
    logic                     unused_hi;

    assign wide      = CAST_W'(x);
    assign res       = fx_cast(wide, IN_FRAC, OUT_FRAC, OUT_W);
    assign y         = res[OUT_W-1:0];
    assign unused_hi = ^res[CAST_W-1:OUT_W];

endmodule

// File: rtl/fixed_shrink_pipe.sv
// Two-stage streaming hard/soft shrink with format conversion.
// Threshold reloads only on the first beat of each frame.
module fixed_shrink_pipe #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int MODE                        = 0,
    parameter int LAMBDA_WIDTH                = DATA_IN_0_PRECISION_0 - 1,
    parameter int LAMBDA_RESET                = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last,
    input  logic [LAMBDA_WIDTH-1:0]           cfg_lambda,
    input  logic                              cfg_lambda_valid
);
    import fixed_shrink_pkg::*;

    localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int TOTAL = DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int BEATS = TOTAL / P;
    localparam int IW    = DATA_IN_0_PRECISION_0;
    localparam int OW    = DATA_OUT_0_PRECISION_0;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam bit   SOFT  = (MODE == int'(SHRINK_SOFT));

    if ((TOTAL % P) != 0) begin : g_bad_size
        $error("tensor size must be a multiple of the parallelism");
    end

    logic [LAMBDA_WIDTH-1:0] pending_lambda;
    logic [LAMBDA_WIDTH-1:0] active_lambda;
    logic [LAMBDA_WIDTH-1:0] lambda_eff;
    logic [CW-1:0]           beat_cnt;
    logic                    first_beat;
    logic                    in_ready;
    logic                    in_accept;
    logic                    s2_ready;
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [IW:0]      ls;
    logic signed [IW:0]      shrink_res [P];
    logic signed [IW:0]      s1_data [P];
    logic [OW-1:0]           cast_res [P];

    assign s2_ready        = !data_out_0_valid || data_out_0_ready;
    assign in_ready        = !s1_valid || s2_ready;
    assign data_in_0_ready = in_ready;
    assign in_accept       = data_in_0_valid && in_ready;
    assign first_beat      = (beat_cnt == '0);
    // Beat 0 already sees the threshold it is about to latch
    assign lambda_eff      = first_beat ? pending_lambda : active_lambda;
    assign ls              = (IW+1)'($signed({1'b0, lambda_eff}));

    for (genvar g = 0; g < P; g++) begin : g_elem
        logic signed [IW:0] xs;
        assign xs = (IW+1)'($signed(data_in_0[g]));
        assign shrink_res[g] = (xs > ls)  ? (SOFT ? xs - ls : xs) :
                               (xs < -ls) ? (SOFT ? xs + ls : xs) : '0;
        fixed_shrink_cast #(
            .IN_W    (IW + 1),
            .IN_FRAC (DATA_IN_0_PRECISION_1),
            .OUT_W   (OW),
            .OUT_FRAC(DATA_OUT_0_PRECISION_1)
        ) u_cast (
            .x(s1_data[g]),
            .y(cast_res[g])
        );
    end

    // Frame beat counter and frame-aligned threshold reload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt       <= '0;
            pending_lambda <= LAMBDA_WIDTH'(LAMBDA_RESET);
            active_lambda  <= LAMBDA_WIDTH'(LAMBDA_RESET);
        end else begin
            if (cfg_lambda_valid) pending_lambda <= cfg_lambda;
            if (in_accept) begin
                if (first_beat) active_lambda <= pending_lambda;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // Stage 1: register the shrink result and the last flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < P; i++) s1_data[i] <= '0;
        end else if (in_ready) begin
            s1_valid <= data_in_0_valid;
            if (data_in_0_valid) begin
                s1_last <= (beat_cnt == LAST_BEAT);
                for (int i = 0; i < P; i++) s1_data[i] <= shrink_res[i];
            end
        end
    end

    // Stage 2: register the converted output; holds while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0_valid <= 1'b0;
            data_out_0_last  <= 1'b0;
            for (int i = 0; i < P; i++) data_out_0[i] <= '0;
        end else if (s2_ready) begin
            data_out_0_valid <= s1_valid;
            if (s1_valid) begin
                data_out_0_last <= s1_last;
                for (int i = 0; i < P; i++) data_out_0[i] <= cast_res[i];
            end
        end
    end

endmodule
